// File: rtl/fp32_add_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp32_add_fsm: serial-input FP32 adder (4x16-bit words in, 32-bit sum out)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp32_add_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        R_I,
  input  logic [15:0] dataIn,
  output logic [31:0] dataOut,
  output logic        r_o,
  output logic [1:0]  err
);

  localparam logic [2:0] c_WAIT_A_HI = 3'd0;
  localparam logic [2:0] c_WAIT_A_LO = 3'd1;
  localparam logic [2:0] c_WAIT_B_HI = 3'd2;
  localparam logic [2:0] c_WAIT_B_LO = 3'd3;
  localparam logic [2:0] c_ALIGN     = 3'd4;
  localparam logic [2:0] c_ADD       = 3'd5;
  localparam logic [2:0] c_NORM      = 3'd6;
  localparam logic [2:0] c_OUT       = 3'd7;

  localparam logic [1:0] c_ERR_OK    = 2'b00;
  localparam logic [1:0] c_ERR_OVF   = 2'b01;
  localparam logic [1:0] c_ERR_INV   = 2'b10;
  localparam logic [1:0] c_ERR_UNF   = 2'b11;

  localparam logic [31:0] c_QNAN     = 32'h7FC0_0000;

  logic [2:0]  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [23:0] big_mant_q, big_mant_d;
  logic [23:0] small_mant_q, small_mant_d;
  logic [7:0]  big_exp_q, big_exp_d;
  logic        sign_q, sign_d;
  logic        sub_q, sub_d;
  logic        special_q, special_d;
  logic [24:0] sum_q, sum_d;
  logic [31:0] data_out_q, data_out_d;
  logic        r_o_q, r_o_d;
  logic [1:0]  err_q, err_d;

  // Alignment: operands with exponent 0 are flushed to signed zero.
  logic [7:0]  w_a_exp, w_b_exp;
  logic        w_a_zero, w_b_zero;
  logic [23:0] w_a_mant, w_b_mant;
  logic [30:0] w_a_mag, w_b_mag;
  logic        w_a_big;
  logic [7:0]  w_big_exp, w_small_exp, w_exp_diff;
  logic [23:0] w_big_mant, w_small_mant, w_small_shifted;
  logic        w_sign, w_sub, w_special;

  assign w_a_exp    = a_q[30:23];
  assign w_b_exp    = b_q[30:23];
  assign w_a_zero   = (w_a_exp == 8'd0);
  assign w_b_zero   = (w_b_exp == 8'd0);
  assign w_a_mant   = w_a_zero ? 24'd0 : {1'b1, a_q[22:0]};
  assign w_b_mant   = w_b_zero ? 24'd0 : {1'b1, b_q[22:0]};
  assign w_a_mag    = w_a_zero ? 31'd0 : a_q[30:0];
  assign w_b_mag    = w_b_zero ? 31'd0 : b_q[30:0];
  assign w_a_big    = (w_a_mag >= w_b_mag);
  assign w_big_exp  = w_a_big ? w_a_exp : w_b_exp;
  assign w_small_exp = w_a_big ? w_b_exp : w_a_exp;
  assign w_big_mant = w_a_big ? w_a_mant : w_b_mant;
  assign w_small_mant = w_a_big ? w_b_mant : w_a_mant;
  assign w_exp_diff = w_big_exp - w_small_exp;
  assign w_small_shifted = (w_exp_diff >= 8'd25) ? 24'd0 : (w_small_mant >> w_exp_diff);
  assign w_sign     = w_a_big ? a_q[31] : b_q[31];
  assign w_sub      = a_q[31] ^ b_q[31];
  assign w_special  = (w_a_exp == 8'hFF) || (w_b_exp == 8'hFF);

  logic [24:0] w_sum;
  assign w_sum = sub_q ? ({1'b0, big_mant_q} - {1'b0, small_mant_q})
                       : ({1'b0, big_mant_q} + {1'b0, small_mant_q});

  // Leading-zero count of the 24-bit magnitude; highest set bit wins.
  logic [4:0] w_lzc;
  always_comb begin
    w_lzc = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (sum_q[i]) w_lzc = 5'(23 - i);
    end
  end

  // Exponent carried in 10 bits so that both overflow and underflow are visible.
  logic [9:0]  w_exp_carry, w_exp_shift, w_norm_exp;
  logic [22:0] w_norm_frac;
  logic        w_ovf, w_unf;

  assign w_exp_carry = {2'b00, big_exp_q} + 10'd1;
  assign w_exp_shift = {2'b00, big_exp_q} - {5'd0, w_lzc};
  assign w_norm_exp  = sum_q[24] ? w_exp_carry : w_exp_shift;
  assign w_norm_frac = sum_q[24] ? sum_q[23:1] : (sum_q[22:0] << w_lzc);
  assign w_ovf = !w_norm_exp[9] && (w_norm_exp[8:0] >= 9'd255);
  assign w_unf = w_norm_exp[9] || (w_norm_exp == 10'd0);

  logic [31:0] w_result;
  logic [1:0]  w_err;
  always_comb begin
    w_result = {sign_q, w_norm_exp[7:0], w_norm_frac};
    w_err    = c_ERR_OK;
    if (special_q) begin
      w_result = c_QNAN;
      w_err    = c_ERR_INV;
    end else if (sum_q == 25'd0) begin
      w_result = 32'd0;
      w_err    = c_ERR_OK;
    end else if (w_ovf) begin
      w_result = {sign_q, 31'h7F80_0000};
      w_err    = c_ERR_OVF;
    end else if (w_unf) begin
      w_result = {sign_q, 31'd0};
      w_err    = c_ERR_UNF;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    big_mant_d   = big_mant_q;
    small_mant_d = small_mant_q;
    big_exp_d    = big_exp_q;
    sign_d       = sign_q;
    sub_d        = sub_q;
    special_d    = special_q;
    sum_d        = sum_q;
    data_out_d   = data_out_q;
    err_d        = err_q;
    r_o_d        = 1'b0;
    case (state_q)
      c_WAIT_A_HI: if (R_I) begin
        a_d[31:16] = dataIn;
        state_d    = c_WAIT_A_LO;
      end
      c_WAIT_A_LO: if (R_I) begin
        a_d[15:0] = dataIn;
        state_d   = c_WAIT_B_HI;
      end
      c_WAIT_B_HI: if (R_I) begin
        b_d[31:16] = dataIn;
        state_d    = c_WAIT_B_LO;
      end
      c_WAIT_B_LO: if (R_I) begin
        b_d[15:0] = dataIn;
        state_d   = c_ALIGN;
      end
      c_ALIGN: begin
        big_mant_d   = w_big_mant;
        small_mant_d = w_small_shifted;
        big_exp_d    = w_big_exp;
        sign_d       = w_sign;
        sub_d        = w_sub;
        special_d    = w_special;
        state_d      = c_ADD;
      end
      c_ADD: begin
        sum_d   = w_sum;
        state_d = c_NORM;
      end
      // Result is registered on the edge into OUT so it is visible during OUT.
      c_NORM: begin
        data_out_d = w_result;
        err_d      = w_err;
        r_o_d      = 1'b1;
        state_d    = c_OUT;
      end
      c_OUT:   state_d = c_WAIT_A_HI;
      default: state_d = c_WAIT_A_HI;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= c_WAIT_A_HI;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      big_mant_q   <= 24'd0;
      small_mant_q <= 24'd0;
      big_exp_q    <= 8'd0;
      sign_q       <= 1'b0;
      sub_q        <= 1'b0;
      special_q    <= 1'b0;
      sum_q        <= 25'd0;
      data_out_q   <= 32'd0;
      r_o_q        <= 1'b0;
      err_q        <= c_ERR_OK;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      big_mant_q   <= big_mant_d;
      small_mant_q <= small_mant_d;
      big_exp_q    <= big_exp_d;
      sign_q       <= sign_d;
      sub_q        <= sub_d;
      special_q    <= special_d;
      sum_q        <= sum_d;
      data_out_q   <= data_out_d;
      r_o_q        <= r_o_d;
      err_q        <= err_d;
    end
  end

  assign dataOut = data_out_q;
  assign r_o     = r_o_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_add_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp32_add_fsm: table-driven scoreboard bench for fp32_add_fsm            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fp32_add_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        R_I;
  logic [15:0] dataIn;
  logic [31:0] dataOut;
  logic        r_o;
  logic [1:0]  err;

  always #5 clk = ~clk;

  fp32_add_fsm dut (
    .clk     (clk),
    .reset   (reset),
    .R_I     (R_I),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .r_o     (r_o),
    .err     (err)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [1:0]  e;
    int          gap;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  logic [33:0] sb_q [$];
  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int expected_pulses = 0;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every r_o pulse pops one expected {err, dataOut}.
  always @(negedge clk) begin
    if (reset === 1'b1 && r_o === 1'b1) begin
      pulses++;
      if (sb_q.size() == 0) begin
        chk("unexpected_r_o", 34'd1, 34'd0);
      end else begin
        chk("result", {err, dataOut}, sb_q.pop_front());
      end
    end
  end

  task automatic send_word(input logic [15:0] w, input int gap);
    repeat (gap) begin
      R_I = 1'b0;
      dataIn = 16'($urandom);
      @(posedge clk); #1;
    end
    R_I = 1'b1;
    dataIn = w;
    @(posedge clk); #1;
    R_I = 1'b0;
  endtask

  // Drives one operation; junk R_I/dataIn during the compute states must be ignored.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [1:0] e, input int gap);
    sb_q.push_back({e, res});
    expected_pulses++;
    send_word(a[31:16], gap);
    send_word(a[15:0], gap);
    send_word(b[31:16], gap);
    send_word(b[15:0], gap);
    for (int k = 1; k <= 4; k++) begin
      R_I = 1'($urandom);
      dataIn = 16'($urandom);
      @(posedge clk); #1;
      chk("r_o_timing", {33'd0, r_o}, {33'd0, (k == 3)});
    end
    R_I = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h40A0_0000, 32'h40E0_0000, 32'h4140_0000, 2'b00, 1};
    vecs[1]  = '{32'h3FC0_0000, 32'h3E80_0000, 32'h3FE0_0000, 2'b00, 0};
    vecs[2]  = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 2'b00, 0};
    vecs[3]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 2'b01, 0};
    vecs[4]  = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 2'b10, 0};
    vecs[5]  = '{32'h00C0_0000, 32'h80A0_0000, 32'h0000_0000, 2'b11, 2};
    vecs[6]  = '{32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 2'b00, 0};
    vecs[7]  = '{32'hFF7F_FFFF, 32'hFF7F_FFFF, 32'hFF80_0000, 2'b01, 0};
    vecs[8]  = '{32'h3F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 2'b10, 0};
    vecs[9]  = '{32'h3F80_0000, 32'hC000_0000, 32'hBF80_0000, 2'b00, 0};
    vecs[10] = '{32'h4C80_0000, 32'h3F80_0000, 32'h4C80_0000, 2'b00, 0};
    vecs[11] = '{32'h4B00_0000, 32'h3F80_0000, 32'h4B00_0001, 2'b00, 0};
    vecs[12] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 2'b00, 0};
    vecs[13] = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 2'b00, 3};
    vecs[14] = '{32'h3F80_0001, 32'hBF80_0000, 32'h3400_0000, 2'b00, 0};

    reset  = 1'b0;
    R_I    = 1'b0;
    dataIn = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {err, r_o, dataOut[30:0]}, 34'd0);
    chk("reset_dataout_msb", {33'd0, dataOut[31]}, 34'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].e, vecs[i].gap);
    end

    // Result must hold through idle cycles.
    repeat (5) @(posedge clk);
    #1;
    chk("hold", {err, dataOut}, {vecs[NVEC-1].e, vecs[NVEC-1].res});

    // Reset mid-operation: partial operands discarded, outputs cleared.
    send_word(16'h3F80, 0);
    send_word(16'h0000, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_outputs", {err, r_o, dataOut[30:0]}, 34'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midreset_hold", {err, r_o, dataOut[30:0]}, 34'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    begin
      int p0;
      p0 = pulses;
      run_op(32'h40A0_0000, 32'h40E0_0000, 32'h4140_0000, 2'b00, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("post_reset_pulses", 34'(pulses - p0), 34'd1);
    end

    // R_I held high through compute, then a back-to-back operation.
    sb_q.push_back({2'b00, 32'h3FE0_0000});
    expected_pulses++;
    send_word(16'h3FC0, 0);
    send_word(16'h0000, 0);
    send_word(16'h3E80, 0);
    send_word(16'h0000, 0);
    R_I = 1'b1;
    dataIn = 16'hFFFF;
    repeat (4) @(posedge clk);
    #1;
    R_I = 1'b0;
    run_op(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 2'b00, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 34'(sb_q.size()), 34'd0);
    chk("pulse_count", 34'(pulses), 34'(expected_pulses));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
